piso_tx: RTL and testbench

- Serial bit-stream transmitter: accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first on a single serial line, with each bit held for a programmable number of clock cycles.
- Provides the driving end for D-input capture stages such as the single-bit flip-flop and shift-register receivers in this codebase.
- Replaces hand-written delay-based stimulus with a synthesizable, cycle-exact source.

---
 rtl/piso_tx.sv | 136 +++++++++++++
 tb/tb_piso_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out bit-stream transmitter.
//
// Behaviour:
//   - A parallel word is accepted through a valid/ready load handshake.
//   - The word is shifted out MSB-first on SOUT.
//   - Each bit is held for BIT_CYCLES clock cycles.
//   - DONE pulses for one cycle after the last bit of a frame.
//
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// (XOR of the captured data) after the data LSB. That bit is held for
// BIT_CYCLES cycles like any data bit.
//
// Handshake: a word is transferred on a rising CK edge where LOAD_VALID=1
// and LOAD_READY=1. LOAD_VALID and LOAD_DATA are ignored while
// LOAD_READY=0. There is no queuing, so the source must hold LOAD_VALID
// until it sees LOAD_READY.
//
// Every output comes straight from a flop. The state is exposed on
// dbg_state (0=IDLE, 1=SHIFT, 2=FIN) so it can be observed from outside.
module piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

`ifdef PISO_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bits on the wire per frame: data bits, plus the parity bit when enabled.
  localparam int FRAME_BITS = WIDTH + PAR_BITS;

  // Counter widths. Each counter is at least one bit wide.
  localparam int BIT_CW  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int HOLD_CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  // Reload values for the counters.
  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(FRAME_BITS - 1);
  localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;      // frame bits still to send; the MSB is on the wire
  logic [BIT_CW-1:0]     bit_cnt;    // bits left after the current one
  logic [HOLD_CW-1:0]    hold_cnt;   // cycles left for the current bit after this one
  logic [FRAME_BITS-1:0] frame_word; // complete frame as captured at the handshake

  // Build the frame from the incoming word. The parity bit, when enabled,
  // is computed from the same data that is captured at the handshake.
`ifdef PISO_TX_PARITY_EN
  assign frame_word = {LOAD_DATA, ^LOAD_DATA};
`else
  assign frame_word = LOAD_DATA;
`endif

  // Sequencer: load on handshake, hold each bit, shift, then one FIN cycle.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      LOAD_READY <= 1'b1;
      SOUT_VALID <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (LOAD_VALID && LOAD_READY) begin
            shreg      <= frame_word;
            bit_cnt    <= BIT_LAST;
            hold_cnt   <= HOLD_LAST;
            LOAD_READY <= 1'b0;
            SOUT_VALID <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (hold_cnt == '0) begin
            hold_cnt <= HOLD_LAST;
            if (bit_cnt == '0) begin
              // The last bit has been held long enough. Clearing the
              // register drives SOUT low for the FIN and IDLE cycles.
              shreg      <= '0;
              SOUT_VALID <= 1'b0;
              DONE       <= 1'b1;
              state      <= FIN;
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        FIN: begin
          DONE       <= 1'b0;
          LOAD_READY <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          shreg      <= '0;
          LOAD_READY <= 1'b1;
          SOUT_VALID <= 1'b0;
          DONE       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // The serial line is the register MSB. The register is zero outside SHIFT.
  assign SOUT      = shreg[FRAME_BITS-1];
  assign dbg_state = state;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx.
//
// Two instances are used:
//   - u_dut:  WIDTH=8, BIT_CYCLES=2
//   - u_dut1: WIDTH=4, BIT_CYCLES=1
//
// Inputs are driven just after the rising edge or at the falling edge.
// Outputs are sampled at the falling edge.
// Each check compares the status vector {LOAD_READY, SOUT_VALID, SOUT, DONE}.
module tb_piso_tx;

  localparam int W  = 8;
  localparam int B  = 2;
`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int N  = (W + PB) * B;   // SOUT_VALID cycles per frame, main instance
  localparam int W1 = 4;
  localparam int N1 = (W1 + PB);      // BIT_CYCLES=1 instance

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         load_ready, sout, sout_valid, done;
  logic [1:0]   st;

  // Single-cycle-bit instance signals
  logic          v1 = 1'b0;
  logic [W1-1:0] d1 = '0;
  logic          r1, s1, sv1, done1;
  logic [1:0]    st1;

  piso_tx #(.WIDTH(W), .BIT_CYCLES(B)) u_dut (
    .CK(clk), .RST_N(rst_n), .LOAD_VALID(load_valid), .LOAD_DATA(load_data),
    .LOAD_READY(load_ready), .SOUT(sout), .SOUT_VALID(sout_valid), .DONE(done),
    .dbg_state(st)
  );

  piso_tx #(.WIDTH(W1), .BIT_CYCLES(1)) u_dut1 (
    .CK(clk), .RST_N(rst_n), .LOAD_VALID(v1), .LOAD_DATA(d1),
    .LOAD_READY(r1), .SOUT(s1), .SOUT_VALID(sv1), .DONE(done1),
    .dbg_state(st1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected wire bit j of a frame: data MSB first, then parity when enabled.
  function automatic logic exp_bit(input logic [W-1:0] d, input int j);
    if (j < W) return d[W-1-j];
    return ^d;
  endfunction

  function automatic logic exp_bit4(input logic [W1-1:0] d, input int j);
    if (j < W1) return d[W1-1-j];
    return ^d;
  endfunction

  // Driver: call at a falling edge while LOAD_READY=1.
  // Presents the word for exactly one rising edge.
  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // Reset state, checked before any clock edge and after clocks under reset.
  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_async: got %b want 100000", {load_ready, sout_valid, sout, done, st});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done, r1, sv1, s1, done1} !== 8'b10001000) begin
      n_errors++;
      $display("FAIL reset_held: got %b want 10001000", {load_ready, sout_valid, sout, done, r1, sv1, s1, done1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_release: got %b want 100000", {load_ready, sout_valid, sout, done, st});
    end
  endtask

  // Basic 8'hA5 frame: 1,0,1,0,0,1,0,1, each bit held for 2 cycles.
  task automatic test_basic;
    logic [W-1:0] d = 8'hA5;
    @(negedge clk);
    load_word(d);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== {1'b0, 1'b1, exp_bit(d, i / B), 1'b0}) begin
        n_errors++;
        $display("FAIL basic_bit cycle %0d: got %b want %b", i + 1,
                 {load_ready, sout_valid, sout, done}, {1'b0, 1'b1, exp_bit(d, i / B), 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b000110) begin
      n_errors++;
      $display("FAIL basic_done: got %b want 000110", {load_ready, sout_valid, sout, done, st});
    end
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
      n_errors++;
      $display("FAIL basic_ready: got %b want 100000", {load_ready, sout_valid, sout, done, st});
    end
  endtask

  // A LOAD_VALID pulse with 8'hFF during a frame must not disturb it.
  task automatic test_busy_ignore;
    logic [W-1:0] d = 8'hA5;
    @(negedge clk);
    load_word(d);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== {1'b0, 1'b1, exp_bit(d, i / B), 1'b0}) begin
        n_errors++;
        $display("FAIL busy_bit cycle %0d: got %b want %b", i + 1,
                 {load_ready, sout_valid, sout, done}, {1'b0, 1'b1, exp_bit(d, i / B), 1'b0});
      end
      if (i == 4) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
      end
      if (i == 5) load_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done} !== 4'b0001) begin
      n_errors++;
      $display("FAIL busy_done: got %b want 0001", {load_ready, sout_valid, sout, done});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
        n_errors++;
        $display("FAIL busy_idle cycle %0d: got %b want 100000", i, {load_ready, sout_valid, sout, done, st});
      end
    end
  endtask

  // LOAD_VALID held high across two frames: 8'h81, then 8'h7E.
  // LOAD_DATA changes to 8'h7E right after the first handshake.
  task automatic test_back_to_back;
    logic [W-1:0] d0 = 8'h81;
    logic [W-1:0] d1w = 8'h7E;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d0;
    @(posedge clk);
    #1 load_data = d1w;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        n_checks++;
        if ({load_ready, sout_valid, sout, done} !==
            {1'b0, 1'b1, exp_bit((f == 0) ? d0 : d1w, i / B), 1'b0}) begin
          n_errors++;
          $display("FAIL b2b_bit frame %0d cycle %0d: got %b want %b", f, i + 1,
                   {load_ready, sout_valid, sout, done},
                   {1'b0, 1'b1, exp_bit((f == 0) ? d0 : d1w, i / B), 1'b0});
        end
      end
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== 4'b0001) begin
        n_errors++;
        $display("FAIL b2b_done frame %0d: got %b want 0001", f, {load_ready, sout_valid, sout, done});
      end
      if (f == 1) load_valid = 1'b0;
      // Single IDLE cycle between the frames. The second handshake happens
      // on the edge that ends this cycle.
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
        n_errors++;
        $display("FAIL b2b_gap frame %0d: got %b want 100000", f, {load_ready, sout_valid, sout, done, st});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
      n_errors++;
      $display("FAIL b2b_no_third: got %b want 100000", {load_ready, sout_valid, sout, done, st});
    end
  endtask

  // BIT_CYCLES=1 instance: 4'b1100 gives 1,1,0,0 on consecutive cycles,
  // then DONE.
  task automatic test_single_cycle;
    logic [W1-1:0] d = 4'b1100;
    @(negedge clk);
    v1 = 1'b1;
    d1 = d;
    @(posedge clk);
    #1 v1 = 1'b0;
    for (int i = 0; i < N1; i++) begin
      @(negedge clk);
      n_checks++;
      if ({r1, sv1, s1, done1} !== {1'b0, 1'b1, exp_bit4(d, i), 1'b0}) begin
        n_errors++;
        $display("FAIL single_bit cycle %0d: got %b want %b", i + 1,
                 {r1, sv1, s1, done1}, {1'b0, 1'b1, exp_bit4(d, i), 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({r1, sv1, s1, done1, st1} !== 6'b000110) begin
      n_errors++;
      $display("FAIL single_done: got %b want 000110", {r1, sv1, s1, done1, st1});
    end
    @(negedge clk);
    n_checks++;
    if ({r1, sv1, s1, done1, st1} !== 6'b100000) begin
      n_errors++;
      $display("FAIL single_ready: got %b want 100000", {r1, sv1, s1, done1, st1});
    end
  endtask

  // Reset asserted between edges during bit 3 of 8'hA5.
  // Then a fresh 8'h3C frame is sent after release.
  task automatic test_reset_mid_frame;
    logic [W-1:0] d  = 8'hA5;
    logic [W-1:0] d2 = 8'h3C;
    @(negedge clk);
    load_word(d);
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done} !== 4'b0110) begin
      n_errors++;
      $display("FAIL mid_before: got %b want 0110", {load_ready, sout_valid, sout, done});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({load_ready, sout_valid, sout, done, st} !== 6'b100000) begin
      n_errors++;
      $display("FAIL mid_async: got %b want 100000", {load_ready, sout_valid, sout, done, st});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== 4'b1000) begin
        n_errors++;
        $display("FAIL mid_quiet cycle %0d: got %b want 1000", i, {load_ready, sout_valid, sout, done});
      end
    end
    load_word(d2);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== {1'b0, 1'b1, exp_bit(d2, i / B), 1'b0}) begin
        n_errors++;
        $display("FAIL mid_fresh cycle %0d: got %b want %b", i + 1,
                 {load_ready, sout_valid, sout, done}, {1'b0, 1'b1, exp_bit(d2, i / B), 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({load_ready, sout_valid, sout, done} !== 4'b0001) begin
      n_errors++;
      $display("FAIL mid_fresh_done: got %b want 0001", {load_ready, sout_valid, sout, done});
    end
    @(negedge clk);
  endtask

  // Frame length and trailing bit.
  // With parity enabled, 8'hA5 gives parity 0 and 8'h07 gives parity 1,
  // and DONE lands in cycle 19. Without parity, DONE lands in cycle 17.
  task automatic test_parity;
    logic [W-1:0] d;
    for (int w = 0; w < 2; w++) begin
      d = (w == 0) ? 8'hA5 : 8'h07;
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== 4'b1000) begin
        n_errors++;
        $display("FAIL parity_pre word %0d: got %b want 1000", w, {load_ready, sout_valid, sout, done});
      end
      load_word(d);
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        n_checks++;
        if ({load_ready, sout_valid, sout, done} !== {1'b0, 1'b1, exp_bit(d, i / B), 1'b0}) begin
          n_errors++;
          $display("FAIL parity_bit word %0d cycle %0d: got %b want %b", w, i + 1,
                   {load_ready, sout_valid, sout, done}, {1'b0, 1'b1, exp_bit(d, i / B), 1'b0});
        end
      end
      @(negedge clk);
      n_checks++;
      if ({load_ready, sout_valid, sout, done} !== 4'b0001) begin
        n_errors++;
        $display("FAIL parity_done word %0d: got %b want 0001", w, {load_ready, sout_valid, sout, done});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_busy_ignore;
    test_back_to_back;
    test_single_cycle;
    test_reset_mid_frame;
    test_parity;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
